sample_queue_seq: RTL and testbench
===================================

Name: sample_queue_seq

Overview:
- Producer side of the band-filter input interface. Buffers incoming left/right audio samples in a circular queue.
- On each new sample, once TAPS samples are held, replays the TAPS most recent samples oldest-first, one per clock, with `sequencing` high for the whole burst.
- Feeds the bank of FIR band filters, which clear their accumulators on the rising edge of `sequencing` and MAC one sample per clock.

Parameters:
- TAPS, 1021, samples per burst; equals filter coefficient count.
- DEPTH, 1536, queue entries per channel; must be > TAPS+2. Not required to be a power of 2.
- W, 16, sample width (signed two's complement, passed through unmodified).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- new_smpl  in  1  one-cycle strobe: lft_smpl/rght_smpl valid this cycle.
- lft_smpl  in  W  left sample from codec interface.
- rght_smpl  in  W  right sample from codec interface.
- sequencing  out  1  high for exactly TAPS consecutive cycles per burst; registered.
- lft_out  out  W  left sample for current burst cycle; 0 when sequencing low; registered.
- rght_out  out  W  right sample for current burst cycle; 0 when sequencing low; registered.
- full  out  1  high once TAPS samples have been captured since reset; sticky.
- ovr  out  1  sticky: a burst request was dropped; cleared only by rst.

Behaviour:
- Reset, asynchronous:
  - sequencing=0, lft_out=0, rght_out=0, full=0, ovr=0.
  - wr_ptr=0, count=0, pending=0, state=FILL.
  - Applies mid-burst: sequencing drops immediately, burst abandoned.
  - Queue contents need not be cleared.
- Storage: two DEPTH x W dual-port RAMs, one write port and one synchronous read port (1-cycle read latency).
- Write:
  - Every new_smpl, in any state, writes both samples at wr_ptr.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
  - count saturates at TAPS.
- Burst window: the TAPS entries ending at the just-written entry.
  - Start rd_ptr = (wr_ptr_after_write - TAPS) mod DEPTH.
  - rd_ptr increments with wrap at DEPTH-1 to 0.
  - The window never overlaps the write location while a burst is running, because DEPTH > TAPS+2.
- States:
  - FILL: count<TAPS.
    - The new_smpl that makes count==TAPS sets full and goes to ARM.
    - Earlier strobes only write.
  - IDLE: new_smpl -> ARM.
  - ARM (1 cycle): loads rd_ptr and issues the first read address.
  - READ: TAPS read addresses issued, one per cycle. After the last one, -> ARM if pending (clear pending), else -> IDLE.
- Timing: if new_smpl is sampled at edge E0, sequencing is high from edge E3 through E3+TAPS-1.
  - lft_out/rght_out in burst cycle k (k=0..TAPS-1) hold window entry k, oldest first.
  - Last cycle carries the sample written at E0.
- Back-to-back bursts: sequencing returns low for at least 1 cycle between bursts, so the consumer sees a fresh rising edge.
- new_smpl during ARM/READ:
  - Sample is written and pending is set.
  - The next burst uses the window ending at the most recent write at the time of its ARM.
  - If pending is already set when another new_smpl arrives, ovr is set, and only one extra burst is issued.
- new_smpl in FILL on the same cycle count reaches TAPS: handled as above, no special case.
- No arithmetic on sample data. Pointer math is modulo DEPTH only.

Test Plan:
- Fill: after rst, feed 1021 strobes, 40 clks apart, with lft=i, rght=-i (i=0..1020).
  - -> no sequencing before strobe #1021; full rises at that strobe.
  - sequencing rises 3 clks later for exactly 1021 cycles; lft_out=0..1020, rght_out=0..-1020 in order; outputs 0 outside the burst.
- Steady state: strobe i=1021 after the burst ends -> burst lft_out=1..1021.
- Wrap: feed 2000 samples with bursts allowed to finish -> each burst n shows lft_out=n..n+1020 across the DEPTH wrap (entries 1535 to 0) with no glitch or duplicate.
- Pending: strobe i=1022 arrives 500 clks into a burst.
  - -> current burst completes unaltered; sequencing low exactly 2 cycles; second burst lft_out=2..1022; ovr stays 0.
- Overrun: two strobes during one burst (i=1022, 1023).
  - -> ovr=1; only one extra burst, lft_out=3..1023.
- Reset mid-burst: assert rst at burst cycle 300.
  - -> sequencing/outputs 0 the same cycle; full=0, ovr=0.
  - After release, 1020 strobes produce no burst; the 1021st does.
- Small config TAPS=4, DEPTH=7: random strobe spacing 0-20 clks checked against a software model of the window and burst timing.

Source files
------------

// File: rtl/sample_queue_seq.sv
// Circular left/right sample queue. On every new sample, once TAPS samples are
// held, it replays the TAPS newest entries oldest-first as one registered burst.
module sample_queue_seq #(
    parameter int TAPS  = 1021,
    parameter int DEPTH = 1536,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_smpl,
    input  logic [W-1:0] lft_smpl,
    input  logic [W-1:0] rght_smpl,
    output logic         sequencing,
    output logic [W-1:0] lft_out,
    output logic [W-1:0] rght_out,
    output logic         full,
    output logic         ovr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] P_TAPS = PW'(TAPS);
    localparam logic [PW-1:0] P_BACK = PW'(DEPTH - TAPS);
    localparam logic [CW-1:0] C_TAPS = CW'(TAPS);
    localparam logic [CW-1:0] C_FILL = CW'(TAPS - 1);

    typedef enum logic [1:0] {FILL, IDLE, ARM, READ} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_inc, w_rd_ptr_inc, w_start;
    logic [CW-1:0] r_count, r_rd_cnt;
    logic          r_pending, w_pend_nxt, w_ovr_set;
    logic          w_rd_en, r_rd_vld;
    logic [W-1:0]  r_lmem [DEPTH];
    logic [W-1:0]  r_rmem [DEPTH];
    logic [W-1:0]  r_lq, r_rq;

    always_comb begin
        w_wr_ptr_inc = (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
        w_rd_ptr_inc = (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
        // Window start = oldest of the TAPS entries ending at the newest write.
        w_start      = (r_wr_ptr >= P_TAPS) ? r_wr_ptr - P_TAPS : r_wr_ptr + P_BACK;
    end

    // READ runs TAPS+1 cycles: TAPS reads plus one turn-around cycle, so a
    // pending burst always leaves sequencing low for two cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pending;
        w_ovr_set   = 1'b0;
        w_rd_en     = (r_state == READ) && (r_rd_cnt != C_TAPS);
        case (r_state)
            FILL: if (new_smpl && r_count == C_FILL) w_state_nxt = ARM;
            IDLE: if (new_smpl) w_state_nxt = ARM;
            ARM: begin
                w_state_nxt = READ;
                if (new_smpl) begin
                    w_ovr_set  = r_pending;
                    w_pend_nxt = 1'b1;
                end
            end
            READ: begin
                if (!w_rd_en) begin
                    w_state_nxt = (r_pending || new_smpl) ? ARM : IDLE;
                    w_pend_nxt  = 1'b0;
                end else if (new_smpl) begin
                    w_ovr_set  = r_pending;
                    w_pend_nxt = 1'b1;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (new_smpl) begin
            r_lmem[r_wr_ptr] <= lft_smpl;
            r_rmem[r_wr_ptr] <= rght_smpl;
        end
        if (w_rd_en) begin
            r_lq <= r_lmem[r_rd_ptr];
            r_rq <= r_rmem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_cnt   <= '0;
            r_pending  <= 1'b0;
            r_rd_vld   <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
            full       <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            ovr       <= ovr | w_ovr_set;
            if (new_smpl) begin
                r_wr_ptr <= w_wr_ptr_inc;
                if (r_count != C_TAPS) r_count <= r_count + CW'(1);
                if (r_count == C_FILL) full <= 1'b1;
            end
            if (r_state == ARM) begin
                r_rd_ptr <= w_start;
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_ptr <= w_rd_ptr_inc;
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
            r_rd_vld   <= w_rd_en;
            sequencing <= r_rd_vld;
            lft_out    <= r_rd_vld ? r_lq : '0;
            rght_out   <= r_rd_vld ? r_rq : '0;
        end
    end
endmodule

// File: tb/tb_sample_queue_seq.sv
// Bench for sample_queue_seq in a small configuration: directed strobe table with
// hand-computed full/ovr, a transaction-level burst model, reset mid-burst, random spacing.
module tb_sample_queue_seq;
    localparam int TAPS = 4, DEPTH = 7, W = 16;

    logic         clk = 1'b0, rst = 1'b1, new_smpl = 1'b0;
    logic [W-1:0] lft_smpl = '0, rght_smpl = '0;
    logic         sequencing, full, ovr;
    logic [W-1:0] lft_out, rght_out;

    sample_queue_seq #(.TAPS(TAPS), .DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst), .new_smpl(new_smpl), .lft_smpl(lft_smpl),
        .rght_smpl(rght_smpl), .sequencing(sequencing), .lft_out(lft_out),
        .rght_out(rght_out), .full(full), .ovr(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           dly;
        logic [W-1:0] l, r;
        logic         xfull, xovr;
    } vec_t;
    vec_t tbl[15];

    int n_tests = 0, n_fail = 0;
    int e = 0, nw = 0;
    logic [W-1:0] wl[1024], wr[1024];
    int m_count = 0, m_L = 0, m_end = 0;
    bit m_full, m_ovr, m_pend, m_busy, m_bv;
    logic         x_seq;
    logic [W-1:0] x_l, x_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_full = 0; m_ovr = 0; m_pend = 0; m_busy = 0; m_bv = 0;
    endtask

    // Burst launched at edge L: outputs at edges L+3..L+TAPS+2, done at L+TAPS+2.
    task automatic model_edge(input logic s, input logic [W-1:0] l, input logic [W-1:0] r);
        bit launch;
        int k;
        x_seq = m_bv && (e >= m_L + 3) && (e <= m_L + TAPS + 2);
        x_l = '0; x_r = '0;
        if (x_seq) begin
            k   = e - m_L - 3;
            x_l = wl[m_end - TAPS + k];
            x_r = wr[m_end - TAPS + k];
        end
        launch = 0;
        if (s) begin
            wl[nw] = l; wr[nw] = r; nw++;
            if (m_count < TAPS) m_count++;
        end
        if (m_busy) begin
            if (e == m_L + TAPS + 2) begin
                if (m_pend || s) launch = 1;
                else m_busy = 0;
                m_pend = 0;
            end else if (s) begin
                if (m_pend) m_ovr = 1;
                else m_pend = 1;
            end
        end else if (s) begin
            if (m_full) launch = 1;
            else if (m_count == TAPS) begin m_full = 1; launch = 1; end
        end
        if (launch) begin
            m_busy = 1; m_bv = 1; m_L = e; m_end = nw;
        end
    endtask

    task automatic step(input logic s, input logic [W-1:0] l, input logic [W-1:0] r);
        new_smpl = s; lft_smpl = l; rght_smpl = r;
        @(posedge clk);
        e++;
        model_edge(s, l, r);
        @(negedge clk);
        new_smpl = 1'b0;
        chk("sequencing", 32'(sequencing), 32'(x_seq));
        chk("lft_out", 32'(lft_out), 32'(x_l));
        chk("rght_out", 32'(rght_out), 32'(x_r));
        chk("full", 32'(full), 32'(m_full));
        chk("ovr", 32'(ovr), 32'(m_ovr));
    endtask

    task automatic strobe_after(input int dly, input logic [W-1:0] l, input logic [W-1:0] r);
        repeat (dly - 1) step(1'b0, '0, '0);
        step(1'b1, l, r);
    endtask

    initial begin
        // dly = edges since previous strobe; comments give the burst situation hit.
        tbl[0]  = '{10, 16'd0,  16'd0,          1'b0, 1'b0};
        tbl[1]  = '{10, 16'd1,  16'hffff,       1'b0, 1'b0};
        tbl[2]  = '{10, 16'd2,  16'hfffe,       1'b0, 1'b0};
        tbl[3]  = '{10, 16'd3,  16'hfffd,       1'b1, 1'b0}; // fills, first burst
        tbl[4]  = '{10, 16'd4,  16'hfffc,       1'b1, 1'b0}; // steady state
        tbl[5]  = '{10, 16'd5,  16'hfffb,       1'b1, 1'b0};
        tbl[6]  = '{4,  16'd6,  16'hfffa,       1'b1, 1'b0}; // mid-burst -> pending
        tbl[7]  = '{10, 16'd7,  16'hfff9,       1'b1, 1'b0};
        tbl[8]  = '{6,  16'd8,  16'hfff8,       1'b1, 1'b0}; // on the done edge
        tbl[9]  = '{10, 16'd9,  16'hfff7,       1'b1, 1'b0};
        tbl[10] = '{5,  16'd10, 16'hfff6,       1'b1, 1'b0}; // last READ cycle
        tbl[11] = '{10, 16'd11, 16'hfff5,       1'b1, 1'b0};
        tbl[12] = '{2,  16'd12, 16'hfff4,       1'b1, 1'b0}; // pending
        tbl[13] = '{1,  16'd13, 16'hfff3,       1'b1, 1'b1}; // overrun
        tbl[14] = '{10, 16'd14, 16'hfff2,       1'b1, 1'b1};

        #12;
        chk("rst_sequencing", 32'(sequencing), 32'd0);
        chk("rst_lft", 32'(lft_out), 32'd0);
        chk("rst_rght", 32'(rght_out), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            strobe_after(tbl[i].dly, tbl[i].l, tbl[i].r);
            chk("tbl_full", 32'(full), 32'(tbl[i].xfull));
            chk("tbl_ovr", 32'(ovr), 32'(tbl[i].xovr));
        end
        repeat (12) step(1'b0, '0, '0);

        // Reset in the middle of a burst.
        strobe_after(1, 16'h0aaa, 16'h0555);
        repeat (4) step(1'b0, '0, '0);
        chk("seq_before_rst", 32'(sequencing), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sequencing", 32'(sequencing), 32'd0);
        chk("midrst_lft", 32'(lft_out), 32'd0);
        chk("midrst_rght", 32'(rght_out), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_ovr", 32'(ovr), 32'd0);
        @(posedge clk);
        e++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < TAPS; i++) begin
            strobe_after(8, 16'(16'h100 + i), 16'(16'h200 + i));
            chk("refill_full", 32'(full), (i == TAPS - 1) ? 32'd1 : 32'd0);
        end
        repeat (10) step(1'b0, '0, '0);

        for (int i = 0; i < 200; i++)
            strobe_after(int'($urandom_range(1, 21)), 16'($urandom), 16'($urandom));
        repeat (12) step(1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
